// File: rtl/imem_aligner_if.sv
// Aligned 64-bit instruction memory read bus.
// The master holds mem_req/mem_addr until the slave returns a one-cycle mem_ack.
interface imem_aligner_if;
  logic [63:0] mem_addr;
  logic        mem_req;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_addr,
    output mem_req,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/imem_aligner.sv
// Instruction fetch aligner: a two-word sliding line buffer over an aligned 64-bit memory.
// It serves any 16-bit-aligned 64-bit window to fetch from registered outputs.
module imem_aligner #(
  parameter bit PREFETCH = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [63:0]    fetch_addr,
  input  logic           fetch_addr_valid,
  output logic [63:0]    fetch_data,
  output logic           fetch_data_valid,
  imem_aligner_if.master mem
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [60:0] tag_reg, tag_next;
  logic [60:0] req_word_reg, req_word_next;
  logic [63:0] w0_reg, w0_next;
  logic [63:0] w1_reg, w1_next;
  logic        v0_reg, v0_next;
  logic        v1_reg, v1_next;
  logic [63:0] fetch_data_reg, fetch_data_next;
  logic        fetch_valid_reg, fetch_valid_next;

  logic [60:0]  addr_word;
  logic [60:0]  tag_p1;
  logic [1:0]   offset;
  logic         at_tag, at_tag_p1, in_buf;
  logic         cover_w, cover_w1, hit;
  logic [127:0] pair;
  logic [63:0]  window [4];
  logic         addr_lsb_unused;

  assign addr_word       = fetch_addr[63:3];
  assign offset          = fetch_addr[2:1];
  assign addr_lsb_unused = fetch_addr[0];
  assign tag_p1          = tag_reg + 61'd1;
  assign at_tag          = (addr_word == tag_reg);
  assign at_tag_p1       = (addr_word == tag_p1);
  assign in_buf          = at_tag || (v1_reg && at_tag_p1);
  assign cover_w         = (v0_reg && at_tag) || (v1_reg && at_tag_p1);
  // W+1 can only be held as slot 1 behind W == T; word T+2 is never buffered.
  assign cover_w1        = v1_reg && at_tag;
  assign hit             = fetch_addr_valid && cover_w && ((offset == 2'd0) || cover_w1);
  // When W == T+1 only offset 0 can hit, so the low half of the pair is a don't-care.
  assign pair            = at_tag ? {w0_reg, w1_reg} : {w1_reg, w1_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_window
      assign window[gi] = pair[127 - 16*gi -: 64];
    end
  endgenerate

  always_comb begin
    state_next       = state_reg;
    tag_next         = tag_reg;
    req_word_next    = req_word_reg;
    w0_next          = w0_reg;
    w1_next          = w1_reg;
    v0_next          = v0_reg;
    v1_next          = v1_reg;
    fetch_valid_next = hit;
    fetch_data_next  = hit ? window[offset] : fetch_data_reg;

    case (state_reg)
      IDLE: begin
        if (fetch_addr_valid) begin
          if (at_tag_p1 && v1_reg) begin
            tag_next = tag_p1;
            w0_next  = w1_reg;
            v0_next  = 1'b1;
            v1_next  = 1'b0;
            if ((offset != 2'd0) || PREFETCH) begin
              req_word_next = tag_p1 + 61'd1;
              state_next    = WAIT;
            end
          end else if (!in_buf) begin
            tag_next      = addr_word;
            v0_next       = 1'b0;
            v1_next       = 1'b0;
            req_word_next = addr_word;
            state_next    = WAIT;
          end else if (!v0_reg) begin
            // Tag already points at W (left over from a flush in WAIT) but word T is missing.
            req_word_next = tag_reg;
            state_next    = WAIT;
          end else if (!v1_reg && ((offset != 2'd0) || PREFETCH)) begin
            req_word_next = tag_p1;
            state_next    = WAIT;
          end
        end
      end

      WAIT: begin
        if (fetch_addr_valid && !in_buf) begin
          tag_next = addr_word;
          v0_next  = 1'b0;
          v1_next  = 1'b0;
        end
        // Match against the post-flush tag so a response from before a jump is dropped.
        if (mem.mem_ack) begin
          if (req_word_reg == tag_next) begin
            w0_next = mem.mem_rdata;
            v0_next = 1'b1;
          end else if (req_word_reg == tag_next + 61'd1) begin
            w1_next = mem.mem_rdata;
            v1_next = 1'b1;
          end
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      tag_reg         <= '0;
      req_word_reg    <= '0;
      w0_reg          <= '0;
      w1_reg          <= '0;
      v0_reg          <= 1'b0;
      v1_reg          <= 1'b0;
      fetch_data_reg  <= '0;
      fetch_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tag_reg         <= tag_next;
      req_word_reg    <= req_word_next;
      w0_reg          <= w0_next;
      w1_reg          <= w1_next;
      v0_reg          <= v0_next;
      v1_reg          <= v1_next;
      fetch_data_reg  <= fetch_data_next;
      fetch_valid_reg <= fetch_valid_next;
    end
  end

  assign mem.mem_req      = (state_reg == WAIT);
  assign mem.mem_addr     = {req_word_reg, 3'b000};
  assign fetch_data       = fetch_data_reg;
  assign fetch_data_valid = fetch_valid_reg;

endmodule
